blk_unpad: RTL and testbench

//  Receive side of the message block path: accepts 512-bit padded message blocks and streams
//  the original 32-bit packets back out. Strips the 0x80000000 pad word, the zero fill and the
//  64-bit length trailer. Reports the recovered message length and flags malformed padding.

---
 rtl/blk_unpad.sv | 213 +++++++++++++++++++++
 tb/tb_blk_unpad.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_unpad.sv
// Receive-side unpadder: takes 512-bit padded blocks and streams the original 32-bit packets,
// dropping the pad word, zero fill and 64-bit length trailer, and flagging malformed padding.
module blk_unpad (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_vld,
  input  logic         blk_last,
  input  logic [511:0] blk,
  output logic         blk_rdy,
  output logic         pkt_vld,
  output logic [31:0]  pkt,
  output logic         pkt_last,
  input  logic         pkt_rdy,
  output logic [63:0]  msg_len,
  output logic         msg_done,
  output logic         pad_err
);

  typedef enum logic [1:0] {IDLE, FLUSH, EMIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [63:0]    ecnt_q, ecnt_d;
  logic           last_q, last_d;
  logic           hold_v_q, hold_v_d;
  logic [63:0]    hold_q, hold_d;
  logic [511:0]   blk_buf_q, blk_buf_d;
  logic [63:0]    msg_len_q, msg_len_d;
  logic           err_pend_q, err_pend_d;
  logic           pkt_vld_q, pkt_vld_d;
  logic [31:0]    pkt_q, pkt_d;
  logic           pkt_last_q, pkt_last_d;
  logic           msg_done_q, msg_done_d;
  logic           pad_err_q, pad_err_d;

  // Padding check on the incoming final block
  logic [63:0]    acc_len;
  logic [63:0]    avail;
  logic [4:0]     nseg;
  logic [4:0]     ndata;
  logic [31:0]    seg [16];
  logic           acc_err;

  logic [63:0]    e_next;
  logic           nxt_flush;
  logic           nxt_end;
  logic [3:0]     nxt_idx;

  // Held word 0 is the older block's word 14, held word 1 its word 15.
  function automatic logic [31:0] word_at(input logic flush, input logic [3:0] p,
                                          input logic [511:0] b, input logic [63:0] h);
    if (flush) return p[0] ? h[63:32] : h[31:0];
    return b[{p, 5'b0} +: 32];
  endfunction

  // The final segment is the held words (if any) followed by words 0..13 of the last block;
  // the pad word must sit right after the data and everything after it must be zero.
  always_comb begin
    acc_len = {blk[479:448], blk[511:480]};
    for (int k = 0; k < 16; k++) seg[k] = '0;
    for (int k = 0; k < 14; k++) begin
      if (hold_v_q) seg[k+2] = blk[32*k +: 32];
      else          seg[k]   = blk[32*k +: 32];
    end
    if (hold_v_q) begin
      seg[0] = hold_q[31:0];
      seg[1] = hold_q[63:32];
    end
    nseg    = hold_v_q ? 5'd16 : 5'd14;
    avail   = ecnt_q + (hold_v_q ? 64'd512 : 64'd448);
    ndata   = 5'((acc_len - ecnt_q) >> 5);
    acc_err = (acc_len[4:0] != 5'd0) || (acc_len > avail) ||
              (acc_len < ecnt_q) || (ndata >= nseg);
    for (int k = 0; k < 16; k++) begin
      if (5'(k) == ndata && seg[k] != 32'h8000_0000) acc_err = 1'b1;
      if (5'(k) > ndata && 5'(k) < nseg && seg[k] != 32'h0) acc_err = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every _d starts at its _q value so no path through the case infers a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    ecnt_d     = ecnt_q;
    last_d     = last_q;
    hold_v_d   = hold_v_q;
    hold_d     = hold_q;
    blk_buf_d  = blk_buf_q;
    msg_len_d  = msg_len_q;
    err_pend_d = err_pend_q;
    pkt_vld_d  = pkt_vld_q;
    pkt_d      = pkt_q;
    pkt_last_d = pkt_last_q;
    msg_done_d = msg_done_q;
    pad_err_d  = pad_err_q;
    e_next     = ecnt_q + 64'd32;
    nxt_flush  = 1'b0;
    nxt_end    = 1'b0;
    nxt_idx    = '0;

    case (state_q)
      IDLE: begin
        if (blk_vld) begin
          blk_buf_d = blk;
          last_d    = blk_last;
          pad_err_d = 1'b0;
          if (blk_last) begin
            msg_len_d  = acc_len;
            err_pend_d = acc_err;
          end
          if (!blk_last || ecnt_q < acc_len) begin
            state_d    = hold_v_q ? FLUSH : EMIT;
            idx_d      = '0;
            pkt_vld_d  = 1'b1;
            pkt_d      = word_at(hold_v_q, 4'd0, blk, hold_q);
            pkt_last_d = blk_last && (e_next == acc_len);
          end else begin
            state_d    = DONE;
            msg_done_d = 1'b1;
            pad_err_d  = acc_err;
          end
        end
      end

      FLUSH, EMIT: begin
        if (pkt_vld_q && pkt_rdy) begin
          ecnt_d = e_next;
          if (state_q == FLUSH) begin
            nxt_flush = !idx_q[0];
            nxt_idx   = idx_q[0] ? 4'd0 : 4'd1;
          end else begin
            nxt_end = (idx_q == 4'd13);
            nxt_idx = idx_q + 4'd1;
          end
          if (!nxt_end && (!last_q || e_next < msg_len_q)) begin
            state_d    = nxt_flush ? FLUSH : EMIT;
            idx_d      = nxt_idx;
            pkt_d      = word_at(nxt_flush, nxt_idx, blk_buf_q, hold_q);
            pkt_last_d = last_q && (e_next + 64'd32 == msg_len_q);
          end else begin
            pkt_vld_d  = 1'b0;
            pkt_last_d = 1'b0;
            if (last_q) begin
              state_d    = DONE;
              msg_done_d = 1'b1;
              pad_err_d  = err_pend_q;
            end else begin
              hold_d   = blk_buf_q[511:448];
              hold_v_d = 1'b1;
              state_d  = IDLE;
            end
          end
        end
      end

      DONE: begin
        msg_done_d = 1'b0;
        ecnt_d     = '0;
        hold_v_d   = 1'b0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ecnt_q     <= '0;
      last_q     <= 1'b0;
      hold_v_q   <= 1'b0;
      hold_q     <= '0;
      msg_len_q  <= '0;
      err_pend_q <= 1'b0;
      pkt_vld_q  <= 1'b0;
      pkt_q      <= '0;
      pkt_last_q <= 1'b0;
      msg_done_q <= 1'b0;
      pad_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ecnt_q     <= ecnt_d;
      last_q     <= last_d;
      hold_v_q   <= hold_v_d;
      hold_q     <= hold_d;
      msg_len_q  <= msg_len_d;
      err_pend_q <= err_pend_d;
      pkt_vld_q  <= pkt_vld_d;
      pkt_q      <= pkt_d;
      pkt_last_q <= pkt_last_d;
      msg_done_q <= msg_done_d;
      pad_err_q  <= pad_err_d;
    end
  end

  // NOTE: the block buffer has no reset; it is always written on accept before any word is read.
  always_ff @(posedge clk) begin
    blk_buf_q <= blk_buf_d;
  end

  assign blk_rdy  = (state_q == IDLE);
  assign pkt_vld  = pkt_vld_q;
  assign pkt      = pkt_q;
  assign pkt_last = pkt_last_q;
  assign msg_len  = msg_len_q;
  assign msg_done = msg_done_q;
  assign pad_err  = pad_err_q;

endmodule

// File: tb/tb_blk_unpad.sv
// Directed bench for blk_unpad: short messages, held-word flush, backpressure, empty message,
// bad padding and reset during a stream.
module tb_blk_unpad;

  logic         clk;
  logic         rst;
  logic         blk_vld;
  logic         blk_last;
  logic [511:0] blk;
  logic         blk_rdy;
  logic         pkt_vld;
  logic [31:0]  pkt;
  logic         pkt_last;
  logic         pkt_rdy;
  logic [63:0]  msg_len;
  logic         msg_done;
  logic         pad_err;

  blk_unpad dut (
    .clk      (clk),
    .rst      (rst),
    .blk_vld  (blk_vld),
    .blk_last (blk_last),
    .blk      (blk),
    .blk_rdy  (blk_rdy),
    .pkt_vld  (pkt_vld),
    .pkt      (pkt),
    .pkt_last (pkt_last),
    .pkt_rdy  (pkt_rdy),
    .msg_len  (msg_len),
    .msg_done (msg_done),
    .pad_err  (pad_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] WA  = 32'hA1A2_A3A4;
  localparam logic [31:0] WB  = 32'hB1B2_B3B4;
  localparam logic [31:0] WC  = 32'hC1C2_C3C4;
  localparam logic [31:0] PAD = 32'h8000_0000;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] got_pkt [$];
  logic        got_last[$];
  int          got_cyc [$];
  int          done_cyc;
  logic        done_seen;
  logic [63:0] got_len;
  logic        got_err;
  int          rdy_hi;
  int          stall_bad;

  logic [511:0] b_abc;
  logic [511:0] b_bad;
  logic [511:0] b_d15;
  logic [511:0] b_l480;
  logic [511:0] b_empty;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one block; returns at the first cycle after the accepting edge.
  task automatic send_blk(input logic last, input logic [511:0] data);
    int w = 0;
    while (!blk_rdy && w < 100) begin
      tick();
      w++;
    end
    check("blk_rdy_wait", 64'(blk_rdy), 64'd1);
    blk_vld  = 1'b1;
    blk_last = last;
    blk      = data;
    tick();
    blk_vld  = 1'b0;
    blk_last = 1'b0;
  endtask

  // Collects packet handshakes until msg_done (or until blk_rdy when until_idle is set).
  // rdy_mode 0: pkt_rdy always 1; rdy_mode 1: pkt_rdy = 1,0,0,1,0,0,...
  task automatic drain(input int max_cyc, input int rdy_mode, input logic until_idle);
    logic        stalled = 1'b0;
    logic [31:0] prev_pkt = '0;
    logic        prev_last = 1'b0;
    got_pkt.delete();
    got_last.delete();
    got_cyc.delete();
    done_seen = 1'b0;
    done_cyc  = -1;
    got_len   = '0;
    got_err   = 1'b0;
    rdy_hi    = 0;
    stall_bad = 0;
    for (int i = 0; i < max_cyc; i++) begin
      pkt_rdy = (rdy_mode == 0) ? 1'b1 : (i % 3 == 0);
      if (msg_done) begin
        done_seen = 1'b1;
        done_cyc  = i;
        got_len   = msg_len;
        got_err   = pad_err;
        break;
      end
      if (until_idle && blk_rdy) begin
        done_seen = 1'b1;
        done_cyc  = i;
        break;
      end
      if (blk_rdy) rdy_hi++;
      if (stalled && (!pkt_vld || pkt !== prev_pkt || pkt_last !== prev_last)) stall_bad++;
      if (pkt_vld && pkt_rdy) begin
        got_pkt.push_back(pkt);
        got_last.push_back(pkt_last);
        got_cyc.push_back(i);
      end
      stalled   = pkt_vld && !pkt_rdy;
      prev_pkt  = pkt;
      prev_last = pkt_last;
      tick();
    end
    check("drain_end_seen", 64'(done_seen), 64'd1);
  endtask

  task automatic check_abc(input string tag, input int exp_done, input logic exp_err);
    check({tag, "_npkt"}, 64'(got_pkt.size()), 64'd3);
    if (got_pkt.size() == 3) begin
      check({tag, "_pkt0"}, 64'(got_pkt[0]), 64'(WA));
      check({tag, "_pkt1"}, 64'(got_pkt[1]), 64'(WB));
      check({tag, "_pkt2"}, 64'(got_pkt[2]), 64'(WC));
      check({tag, "_last"}, 64'({got_last[0], got_last[1], got_last[2]}), 64'b001);
    end
    check({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
    check({tag, "_msg_len"}, got_len, 64'd96);
    check({tag, "_pad_err"}, 64'(got_err), 64'(exp_err));
    check({tag, "_rdy_busy"}, 64'(rdy_hi), 64'd0);
    check({tag, "_stall"}, 64'(stall_bad), 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    blk_vld  = 1'b0;
    blk_last = 1'b0;
    blk      = '0;
    pkt_rdy  = 1'b0;

    b_abc = '0;
    b_abc[0 +: 32]   = WA;
    b_abc[32 +: 32]  = WB;
    b_abc[64 +: 32]  = WC;
    b_abc[96 +: 32]  = PAD;
    b_abc[480 +: 32] = 32'd96;
    b_bad = b_abc;
    b_bad[96 +: 32]  = 32'h0000_0001;
    b_d15 = '0;
    for (int k = 0; k < 15; k++) b_d15[32*k +: 32] = 32'h1000_0000 + 32'(k);
    b_d15[480 +: 32] = PAD;
    b_l480 = '0;
    b_l480[480 +: 32] = 32'd480;
    b_empty = '0;
    b_empty[0 +: 32] = PAD;

    // Reset state
    #1;
    check("rst_blk_rdy", 64'(blk_rdy), 64'd1);
    check("rst_pkt_vld", 64'(pkt_vld), 64'd0);
    check("rst_pkt", 64'(pkt), 64'd0);
    check("rst_pkt_last", 64'(pkt_last), 64'd0);
    check("rst_msg_len", msg_len, 64'd0);
    check("rst_msg_done", 64'(msg_done), 64'd0);
    check("rst_pad_err", 64'(pad_err), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single last block, A,B,C at full rate
    send_blk(1'b1, b_abc);
    drain(50, 0, 1'b0);
    check_abc("t2", 3, 1'b0);
    if (got_cyc.size() == 3)
      check("t2_cycles", 64'({got_cyc[0][7:0], got_cyc[1][7:0], got_cyc[2][7:0]}), 64'h000102);
    tick();
    check("t2_done_pulse", 64'(msg_done), 64'd0);
    check("t2_rdy_after", 64'(blk_rdy), 64'd1);

    // 15-word message over two blocks
    send_blk(1'b0, b_d15);
    drain(50, 0, 1'b1);
    check("t3a_npkt", 64'(got_pkt.size()), 64'd14);
    if (got_pkt.size() == 14) begin
      check("t3a_pkt0", 64'(got_pkt[0]), 64'h1000_0000);
      check("t3a_pkt13", 64'(got_pkt[13]), 64'h1000_000D);
      check("t3a_last13", 64'(got_last[13]), 64'd0);
    end
    send_blk(1'b1, b_l480);
    drain(50, 0, 1'b0);
    check("t3b_npkt", 64'(got_pkt.size()), 64'd1);
    if (got_pkt.size() == 1) begin
      check("t3b_pkt", 64'(got_pkt[0]), 64'h1000_000E);
      check("t3b_last", 64'(got_last[0]), 64'd1);
    end
    check("t3b_msg_len", got_len, 64'd480);
    check("t3b_pad_err", 64'(got_err), 64'd0);
    tick();

    // Backpressure 1,0,0,1,...
    send_blk(1'b1, b_abc);
    drain(50, 1, 1'b0);
    check_abc("t4", 7, 1'b0);
    pkt_rdy = 1'b1;
    tick();

    // Empty message
    send_blk(1'b1, b_empty);
    drain(20, 0, 1'b0);
    check("t5_npkt", 64'(got_pkt.size()), 64'd0);
    check("t5_done_cyc", 64'(done_cyc), 64'd0);
    check("t5_msg_len", got_len, 64'd0);
    check("t5_pad_err", 64'(got_err), 64'd0);
    tick();

    // Bad pad word, sticky until next accept
    send_blk(1'b1, b_bad);
    drain(50, 0, 1'b0);
    check_abc("t6", 3, 1'b1);
    tick();
    check("t6_sticky", 64'(pad_err), 64'd1);
    send_blk(1'b1, b_abc);
    check("t6_cleared", 64'(pad_err), 64'd0);
    drain(50, 0, 1'b0);
    check_abc("t6b", 3, 1'b0);
    tick();

    // Reset mid-EMIT with held words pending
    send_blk(1'b0, b_d15);
    drain(50, 0, 1'b1);
    send_blk(1'b0, b_d15);
    tick();
    tick();
    check("t1_mid_vld", 64'(pkt_vld), 64'd1);
    rst = 1'b1;
    #1;
    check("t1_rst_pkt_vld", 64'(pkt_vld), 64'd0);
    check("t1_rst_blk_rdy", 64'(blk_rdy), 64'd1);
    check("t1_rst_pkt", 64'(pkt), 64'd0);
    #2;
    rst = 1'b0;
    tick();
    send_blk(1'b1, b_abc);
    drain(50, 0, 1'b0);
    check_abc("t1_after", 3, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
